// File: rtl/apb_regbank_pkg.sv
// Shared types and constants for the APB register bank.
package apb_regbank_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam int DEFAULT_WAIT_CYCLES = 0;
    localparam int MAX_WAIT_CYCLES     = 15;

    // Number of byte-offset address bits below the register index field.
    function automatic int off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb_regbank_decode.sv
// Address/direction decode of a captured APB transfer: register index,
// misaligned/out-of-range error, write to read-only error, write enable.
module apb_regbank_decode
    import apb_regbank_pkg::*;
#(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  ADDR_WIDTH = 16,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    localparam int                 IDX_W      = $clog2(NUM_REGS)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  write,
    output logic [IDX_W-1:0]      idx,
    output logic                  addr_err,
    output logic                  ro_err,
    output logic                  wr_en
);

    localparam int OFF_W = off_bits(DATA_WIDTH);
    // Shifts and masks rather than slices so an 8-bit bus (no offset bits) still elaborates.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    // Split the address into offset / index / upper bits and classify the access.
    always_comb begin
        idx      = IDX_W'(addr >> OFF_W);
        addr_err = (|(addr & LOW_MASK)) || (|(addr >> (OFF_W + IDX_W)));
        ro_err   = write && !addr_err && RO_MASK[idx];
        wr_en    = write && !addr_err && !RO_MASK[idx];
    end

endmodule

// File: rtl/apb_regbank.sv
// APB slave with an integrated register bank, programmable wait states,
// PSLVERR responses and read-only hardware-status registers.
// Optional byte strobes: define APB_REGBANK_STRB_EN to add the PSTRB port.
module apb_regbank
    import apb_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    NUM_REGS    = 16,
    parameter int                    WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSELx,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
`ifdef APB_REGBANK_STRB_EN
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
`endif
    output logic                           PREADY,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int NB    = DATA_WIDTH / 8;

    state_e                              state, state_nxt;
    logic [3:0]                          cnt;
    logic [ADDR_WIDTH-1:0]               cap_addr;
    logic                                cap_write;
    logic [DATA_WIDTH-1:0]               cap_wdata;
`ifdef APB_REGBANK_STRB_EN
    logic [NB-1:0]                       cap_strb;
`endif
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] hw_vec;
    logic [IDX_W-1:0]                    idx;
    logic                                addr_err, ro_err, wr_en;
    logic                                setup, capture, commit;
    logic [DATA_WIDTH-1:0]               wmask, rd_val;

    assign setup  = PSELx && !PENABLE;
    assign hw_vec = hw_status;

    apb_regbank_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .RO_MASK    (RO_MASK)
    ) u_decode (
        .addr     (cap_addr),
        .write    (cap_write),
        .idx      (idx),
        .addr_err (addr_err),
        .ro_err   (ro_err),
        .wr_en    (wr_en)
    );

    // Next-state logic; capture/commit strobes drive the datapath below.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: if (setup) begin
                capture   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (!PSELx) begin
                    state_nxt = IDLE;           // abort: nothing committed
                end else if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (setup) begin
                    capture   = 1'b1;           // back-to-back setup during the ready cycle
                    state_nxt = WAIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Byte-lane write mask for the captured transfer.
    always_comb begin
        wmask = '1;
`ifdef APB_REGBANK_STRB_EN
        for (int b = 0; b < NB; b++) wmask[b*8 +: 8] = {8{cap_strb[b]}};
`endif
    end

    assign rd_val = RO_MASK[idx] ? hw_vec[idx] : regs[idx];

    // Transfer capture, wait counter and registered response.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
`ifdef APB_REGBANK_STRB_EN
            cap_strb  <= '0;
`endif
            PREADY    <= 1'b0;
            PRDATA    <= '0;
            PSLVERR   <= 1'b0;
        end else begin
            PREADY <= commit;
            if (capture) begin
                cap_addr  <= PADDR;
                cap_write <= PWRITE;
                cap_wdata <= PWDATA;
`ifdef APB_REGBANK_STRB_EN
                cap_strb  <= PSTRB;
`endif
                cnt       <= 4'(WAIT_CYCLES);
                PRDATA    <= '0;
                PSLVERR   <= 1'b0;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                PSLVERR <= addr_err || ro_err;
                PRDATA  <= (!cap_write && !addr_err) ? rd_val : '0;
            end
        end
    end

    // Register storage; only writable registers are ever updated.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            regs <= {NUM_REGS{RESET_VALUE}};
        end else if (commit && wr_en) begin
            regs[idx] <= (regs[idx] & ~wmask) | (cap_wdata & wmask);
        end
    end

    // Export: read-only slots show the live hardware status.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? hw_vec[i] : regs[i];
    end

endmodule

// File: tb/tb_apb_regbank.sv
// Directed scoreboard bench for apb_regbank (WAIT_CYCLES=3, register 1 read-only).
module tb_apb_regbank;

    localparam int          WC = 3;
    localparam logic [15:0] RO = 16'h0002;

    logic         PCLK = 1'b0;
    logic         PRESETn = 1'b0;
    logic         PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [15:0]  PADDR = '0;
    logic [31:0]  PWDATA = '0;
`ifdef APB_REGBANK_STRB_EN
    logic [3:0]   PSTRB = 4'hF;
`endif
    logic         PREADY, PSLVERR;
    logic [31:0]  PRDATA;
    logic [511:0] hw_status, reg_q;

    always #5 PCLK = ~PCLK;

    apb_regbank #(
        .DATA_WIDTH (32), .ADDR_WIDTH (16), .NUM_REGS (16), .WAIT_CYCLES (WC),
        .RO_MASK (RO), .RESET_VALUE (32'h0)
    ) dut (
        .PCLK (PCLK), .PRESETn (PRESETn), .PSELx (PSELx), .PENABLE (PENABLE),
        .PWRITE (PWRITE), .PADDR (PADDR), .PWDATA (PWDATA),
`ifdef APB_REGBANK_STRB_EN
        .PSTRB (PSTRB),
`endif
        .PREADY (PREADY), .PRDATA (PRDATA), .PSLVERR (PSLVERR),
        .hw_status (hw_status), .reg_q (reg_q)
    );

    typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
    exp_t        sb[$];
    logic [31:0] model [16];
    int          n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: decide error/read data and update the model on good writes.
    task automatic push_exp(input logic wr, input logic [15:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        exp_t        e;
        logic [3:0]  i, sv;
        logic        err;
        logic [31:0] m;
        i   = a[5:2];
`ifdef APB_REGBANK_STRB_EN
        sv  = s;
`else
        sv  = s | 4'hF;
`endif
        m   = {{8{sv[3]}}, {8{sv[2]}}, {8{sv[1]}}, {8{sv[0]}}};
        err = (a[1:0] != 2'b0) || (a[15:6] != 10'b0) || (wr && RO[i]);
        if (wr && !err) model[i] = (model[i] & ~m) | (d & m);
        e.rdata = (!wr && !err) ? (RO[i] ? hw_status[i*32 +: 32] : model[i]) : 32'h0;
        e.err   = err;
        sb.push_back(e);
    endtask

    // One APB transfer starting now (caller positions at a negedge).
    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        int   lat;
        exp_t e;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
`ifdef APB_REGBANK_STRB_EN
        PSTRB = s;
`endif
        push_exp(wr, a, d, s);
        @(negedge PCLK);
        PENABLE = 1'b1;
        check("ready_first_cycle", 64'(PREADY), 64'(0));
        check("prdata_cleared", 64'(PRDATA), 64'(0));
        lat = 1;
        while (!PREADY && lat < 30) begin
            @(negedge PCLK);
            lat++;
        end
        check("latency", 64'(lat), 64'(WC + 2));
        e = sb.pop_front();
        check("prdata", 64'(PRDATA), 64'(e.rdata));
        check("pslverr", 64'(PSLVERR), 64'(e.err));
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) hw_status[i*32 +: 32] = 32'hA500_0000 + i;
        hw_status[32 +: 32] = 32'h0000_1234;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;

        // Reset state
        repeat (2) @(negedge PCLK);
        check("rst_pready", 64'(PREADY), 64'(0));
        check("rst_prdata", 64'(PRDATA), 64'(0));
        check("rst_pslverr", 64'(PSLVERR), 64'(0));
        check("rst_reg0", 64'(reg_q[31:0]), 64'(0));
        check("rst_reg1_ro", 64'(reg_q[63:32]), 64'(32'h1234));
        PRESETn = 1'b1;

        // Read every register after reset
        for (int i = 0; i < 16; i++) begin
            @(negedge PCLK);
            xfer(1'b0, 16'(i * 4), 32'h0, 4'hF);
        end

        // Write/read back with visibility on reg_q in the ready cycle
        @(negedge PCLK); xfer(1'b1, 16'h0008, 32'hDEADBEEF, 4'hF);
        check("reg_q2_on_ready", 64'(reg_q[95:64]), 64'(32'hDEADBEEF));
        @(negedge PCLK); xfer(1'b0, 16'h0008, 32'h0, 4'hF);

        // Read-only register: write rejected, read returns hw_status
        @(negedge PCLK); xfer(1'b1, 16'h0004, 32'h0000FFFF, 4'hF);
        @(negedge PCLK); xfer(1'b0, 16'h0004, 32'h0, 4'hF);
        check("reg_q1_ro", 64'(reg_q[63:32]), 64'(32'h1234));

        // Misaligned and out-of-range addresses
        @(negedge PCLK); xfer(1'b0, 16'h0041, 32'h0, 4'hF);
        @(negedge PCLK); xfer(1'b0, 16'h0040, 32'h0, 4'hF);
        @(negedge PCLK); xfer(1'b1, 16'h0042, 32'h11111111, 4'hF);
        @(negedge PCLK); xfer(1'b1, 16'h8000, 32'h22222222, 4'hF);

        // Back-to-back: new setup in the ready cycle
        @(negedge PCLK); xfer(1'b1, 16'h0014, 32'h5555AAAA, 4'hF);
        xfer(1'b0, 16'h0014, 32'h0, 4'hF);
        xfer(1'b0, 16'h003C, 32'h0, 4'hF);

        // Byte strobes (full word when the strobe port is not built)
        @(negedge PCLK); xfer(1'b1, 16'h000C, 32'hAABBCCDD, 4'b0101);
        @(negedge PCLK); xfer(1'b1, 16'h000C, 32'hFFFFFFFF, 4'b0000);
        @(negedge PCLK); xfer(1'b0, 16'h000C, 32'h0, 4'hF);

        // Abort by dropping PSELx during WAIT: no write
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0018; PWDATA = 32'h77777777;
        @(negedge PCLK); PENABLE = 1'b1;
        @(negedge PCLK); PSELx = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check("abort_no_ready", 64'(PREADY), 64'(0));
        check("abort_reg6", 64'(reg_q[223:192]), 64'(0));
        @(negedge PCLK); xfer(1'b0, 16'h0018, 32'h0, 4'hF);

        // Reset during WAIT of a write to 0x000C
        @(negedge PCLK); xfer(1'b0, 16'h0014, 32'h0, 4'hF);    // leaves PRDATA nonzero
        @(negedge PCLK);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h000C; PWDATA = 32'h12345678;
        @(negedge PCLK); PENABLE = 1'b1;
        @(negedge PCLK); PRESETn = 1'b0;
        #1;
        check("midrst_pready", 64'(PREADY), 64'(0));
        check("midrst_prdata", 64'(PRDATA), 64'(0));
        check("midrst_pslverr", 64'(PSLVERR), 64'(0));
        check("midrst_reg3", 64'(reg_q[127:96]), 64'(0));
        check("midrst_reg5", 64'(reg_q[191:160]), 64'(0));
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        PSELx = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK); PRESETn = 1'b1;
        @(negedge PCLK); xfer(1'b0, 16'h000C, 32'h0, 4'hF);
        @(negedge PCLK); xfer(1'b0, 16'h0008, 32'h0, 4'hF);

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
